// File: rtl/counter_pkg.sv
// counter_pkg: shared direction enum and default constants for the counter
package counter_pkg;
  typedef enum logic {CNT_UP, CNT_DOWN} cnt_dir_e;
  localparam int CNT_WIDTH = 4;
  localparam int CNT_STEP  = 1;
endpackage

// File: rtl/counter_next.sv
// counter_next: combinational modulo-(MAX_VAL+1) next-value function
module counter_next
  import counter_pkg::*;
#(
  parameter int              WIDTH   = CNT_WIDTH,
  parameter cnt_dir_e        DIR     = CNT_UP,
  parameter longint unsigned STEP    = CNT_STEP,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 1
) (
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] nxt
);
  localparam logic [WIDTH:0] S  = STEP[WIDTH:0];
  localparam logic [WIDTH:0] M  = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH:0] M1 = M + 1'b1;
  logic [WIDTH:0] c, sum;
  always_comb begin
    c   = {1'b0, count};
    sum = c + S;
    // down wrap adds (M1 - S) rather than M1 first so the sum never exceeds M1
    nxt = DIR == CNT_UP ? WIDTH'(sum > M ? sum - M1 : sum)
                        : WIDTH'(c >= S ? c - S : c + (M1 - S));
  end
endmodule

// File: rtl/counter.sv
// counter: registered free-running up/down modulo counter with sync reset
module counter
  import counter_pkg::*;
#(
  parameter int              WIDTH   = CNT_WIDTH,
  parameter cnt_dir_e        DIR     = CNT_UP,
  parameter longint unsigned STEP    = CNT_STEP,
  parameter longint unsigned MAX_VAL = (64'd1 << WIDTH) - 1,
  parameter longint unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);
  localparam logic [WIDTH:0]   M = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH-1:0] R = RST_VAL[WIDTH-1:0];
  if (WIDTH < 1 || WIDTH > 32 || STEP < 1 || STEP > MAX_VAL ||
      MAX_VAL > (64'd1 << WIDTH) - 1 || RST_VAL > MAX_VAL) begin : g_bad_params
    $fatal(1, "counter: illegal parameter set");
  end
  logic [WIDTH-1:0] nxt;
  counter_next #(.WIDTH(WIDTH), .DIR(DIR), .STEP(STEP), .MAX_VAL(MAX_VAL)) u_next (
    .count(count),
    .nxt  (nxt)
  );
  // an out-of-range value can only come from a missing reset; recover to RST_VAL
  always_ff @(posedge clk)
    if (rst || {1'b0, count} > M) count <= R;
    else count <= nxt;
endmodule

// File: tb/tb_counter.sv
// tb_counter: directed checks of default, down and modulo-10 counter variants
module tb_counter;
  import counter_pkg::*;
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic [3:0] cnt_def, cnt_dn, cnt_mod;
  int total = 0;
  int bad = 0;
  always #10 clk = ~clk;
  counter u_def (.clk(clk), .rst(rst_a), .count(cnt_def));
  counter #(.DIR(CNT_DOWN), .RST_VAL(3)) u_dn (.clk(clk), .rst(rst_b), .count(cnt_dn));
  counter #(.MAX_VAL(9), .STEP(3)) u_mod (.clk(clk), .rst(rst_b), .count(cnt_mod));
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  logic [3:0] dn_exp [8] = '{4'd2, 4'd1, 4'd0, 4'd15, 4'd14, 4'd13, 4'd12, 4'd11};
  logic [3:0] mod_exp[8] = '{4'd3, 4'd6, 4'd9, 4'd2, 4'd5, 4'd8, 4'd1, 4'd4};
  initial begin
    #1;
    step;
    chk("rst_def", cnt_def, 4'd0);
    chk("rst_dn", cnt_dn, 4'd3);
    chk("rst_mod", cnt_mod, 4'd0);
    step;
    chk("held_def", cnt_def, 4'd0);
    chk("held_dn", cnt_dn, 4'd3);
    chk("held_mod", cnt_mod, 4'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step;
      chk($sformatf("run_def%0d", i), cnt_def, 4'(i % 16));
      if (i <= 8) begin
        chk($sformatf("run_dn%0d", i), cnt_dn, dn_exp[i-1]);
        chk($sformatf("run_mod%0d", i), cnt_mod, mod_exp[i-1]);
      end
    end
    step;
    chk("pre9", cnt_def, 4'd9);
    rst_a = 1'b1;
    step;
    chk("rst_at9", cnt_def, 4'd0);
    rst_a = 1'b0;
    step;
    chk("post9", cnt_def, 4'd1);
    repeat (14) step;
    chk("pre15", cnt_def, 4'd15);
    rst_a = 1'b1;
    step;
    chk("rst_at15", cnt_def, 4'd0);
    rst_a = 1'b0;
    step;
    chk("post15", cnt_def, 4'd1);
    step;
    chk("post15b", cnt_def, 4'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
